// File: rtl/approx_mult_pipe.sv
// -----------------------------------------------------------------------------
// approx_mult_pipe
//   Three-stage valid/ready pipelined unsigned W x W multiplier. Each
//   transaction selects exact or approximate mode. In approximate mode the low
//   APPROX_COLS product columns are OR-compressed and generate no carry. Above
//   those columns the product is summed exactly.
//
//   Stage S1 registers the operands and the mode bit.
//   Stage S2 carry-save reduces the partial-product rows to two rows.
//   Stage S3 performs the carry-propagate add and drives out_p.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand handshake; in_ready = !out_valid | out_ready
//   in_a, in_b      unsigned operands (W bits)
//   in_approx       1 = approximate mode for this transaction
//   out_valid/ready product handshake
//   out_p           product (2W bits)
//   out_approx      mode tag that travels with out_p
//   approx_cnt      saturating count of accepted approximate transactions
// -----------------------------------------------------------------------------
module approx_mult_pipe #(
  parameter int W           = 16,
  parameter int APPROX_COLS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             out_approx,
  output logic [CNT_W-1:0] approx_cnt
);

  localparam int PW = 2 * W;

  // Bit c is set for every column c that is approximated.
  function automatic logic [PW-1:0] low_mask_f();
    logic [PW-1:0] m;
    m = '0;
    for (int c = 0; c < PW; c++) m[c] = (c < APPROX_COLS);
    return m;
  endfunction

  localparam logic [PW-1:0] LOW_MASK = low_mask_f();

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic             s1_approx_q, s1_approx_d;
  logic             s2_valid_q, s2_valid_d;
  logic [PW-1:0]    s2_row0_q, s2_row0_d;
  logic [PW-1:0]    s2_row1_q, s2_row1_d;
  logic             s2_approx_q, s2_approx_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_p_q, out_p_d;
  logic             out_approx_q, out_approx_d;
  logic [CNT_W-1:0] approx_cnt_q, approx_cnt_d;

  // Reduction temporaries
  logic          en;
  logic          accept;
  logic [PW-1:0] keep_mask;
  logic [PW-1:0] pp_row;
  logic [PW-1:0] low_or;
  logic [PW-1:0] acc_s;
  logic [PW-1:0] acc_c;
  logic [PW-1:0] nxt_c;
  logic [PW-1:0] red_row0;
  logic [PW-1:0] red_row1;

  // Every stage advances together. A stall therefore freezes the whole pipe,
  // bubbles included.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  // S2 combinational reduction. The partial-product rows pass through a chain
  // of 3:2 compressors. In approximate mode the low columns are masked out of
  // the chain. That leaves the carry-save rows zero there, so no carry can
  // leave a low column. The OR of each low column is then merged into row 0.
  always_comb begin
    // NOTE: every variable written here gets a value before any conditional
    // use. Otherwise a path that skips the assignment infers a latch.
    keep_mask = s1_approx_q ? ~LOW_MASK : '1;
    pp_row    = '0;
    nxt_c     = '0;
    low_or    = '0;
    acc_s     = '0;
    acc_c     = '0;
    for (int i = 0; i < W; i++) begin
      pp_row = {{W{1'b0}}, s1_a_q & {W{s1_b_q[i]}}} << i;
      low_or = low_or | pp_row;
      pp_row = pp_row & keep_mask;
      nxt_c  = ((acc_s & acc_c) | (acc_s & pp_row) | (acc_c & pp_row)) << 1;
      acc_s  = acc_s ^ acc_c ^ pp_row;
      acc_c  = nxt_c;
    end
    red_row0 = acc_s | (low_or & LOW_MASK & {PW{s1_approx_q}});
    red_row1 = acc_c;
  end

  // Next-state logic for all stages and the counter.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_approx_d  = s1_approx_q;
    s2_valid_d   = s2_valid_q;
    s2_row0_d    = s2_row0_q;
    s2_row1_d    = s2_row1_q;
    s2_approx_d  = s2_approx_q;
    out_valid_d  = out_valid_q;
    out_p_d      = out_p_q;
    out_approx_d = out_approx_q;
    approx_cnt_d = approx_cnt_q;

    if (en) begin
      s1_valid_d   = in_valid;
      s2_valid_d   = s1_valid_q;
      s2_row0_d    = red_row0;
      s2_row1_d    = red_row1;
      s2_approx_d  = s1_approx_q;
      out_valid_d  = s2_valid_q;
      out_p_d      = s2_row0_q + s2_row1_q;
      out_approx_d = s2_approx_q;
      // Operand registers load only on a real acceptance, so idle cycles do
      // not toggle the datapath.
      if (accept) begin
        s1_a_d      = in_a;
        s1_b_d      = in_b;
        s1_approx_d = in_approx;
      end
    end

    if (accept && in_approx && (approx_cnt_q != {CNT_W{1'b1}}))
      approx_cnt_d = approx_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments. All flops then
    // sample the values from before the edge, whatever the statement order.
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_approx_q  <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_row0_q    <= '0;
      s2_row1_q    <= '0;
      s2_approx_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_p_q      <= '0;
      out_approx_q <= 1'b0;
      approx_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_approx_q  <= s1_approx_d;
      s2_valid_q   <= s2_valid_d;
      s2_row0_q    <= s2_row0_d;
      s2_row1_q    <= s2_row1_d;
      s2_approx_q  <= s2_approx_d;
      out_valid_q  <= out_valid_d;
      out_p_q      <= out_p_d;
      out_approx_q <= out_approx_d;
      approx_cnt_q <= approx_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_p      = out_p_q;
  assign out_approx = out_approx_q;
  assign approx_cnt = approx_cnt_q;

endmodule

// File: tb/tb_approx_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_approx_mult_pipe
//   Directed bench for approx_mult_pipe with W=16, APPROX_COLS=8 and a 4-bit
//   counter, so that counter saturation can be reached. Expected products are
//   worked out by hand from the column model. A streaming task drives the
//   vectors back to back and checks order, latency, stall hold and throughput.
// -----------------------------------------------------------------------------
module tb_approx_mult_pipe;

  localparam int W     = 16;
  localparam int K     = 8;
  localparam int CNT_W = 4;
  localparam int PW    = 2 * W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_p;
  logic             out_approx;
  logic [CNT_W-1:0] approx_cnt;

  approx_mult_pipe #(.W(W), .APPROX_COLS(K), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_approx  (in_approx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .out_approx (out_approx),
    .approx_cnt (approx_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Vector table used by run_stream
  logic [W-1:0]  va[$];
  logic [W-1:0]  vb[$];
  logic          vm[$];
  logic [PW-1:0] vp[$];

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic m, input logic [PW-1:0] p);
    va.push_back(a);
    vb.push_back(b);
    vm.push_back(m);
    vp.push_back(p);
  endtask

  task automatic clear_vecs();
    va.delete();
    vb.delete();
    vm.delete();
    vp.delete();
  endtask

  // Drives the table back to back. The task is entered 1 time unit after a
  // rising edge. out_ready is low for stall_len cycles starting at stall_at.
  task automatic run_stream(input string tag, input int stall_at, input int stall_len);
    int  sent = 0;
    int  rcvd = 0;
    int  cyc  = 0;
    int  n    = vp.size();
    bit  stalled;
    while (rcvd < n && cyc < 500) begin
      stalled   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      out_ready = !stalled;
      if (sent < n) begin
        in_valid  = 1'b1;
        in_a      = va[sent];
        in_b      = vb[sent];
        in_approx = vm[sent];
      end else begin
        in_valid  = 1'b0;
      end
      #1;
      if (stalled) begin
        check({tag, "_stall_in_ready"}, in_ready, 0);
        check({tag, "_stall_valid"}, out_valid, 1);
        check({tag, "_stall_hold_p"}, out_p, vp[rcvd]);
        check({tag, "_stall_hold_m"}, out_approx, vm[rcvd]);
      end else begin
        if (rcvd > 0) check({tag, "_no_bubble"}, out_valid, 1);
        if (out_valid) begin
          if (rcvd == 0) check({tag, "_latency"}, cyc, 3);
          check({tag, "_p"}, out_p, vp[rcvd]);
          check({tag, "_m"}, out_approx, vm[rcvd]);
          rcvd++;
        end
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_count"}, rcvd, n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_approx = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_approx", out_approx, 0);
    check("rst_cnt", approx_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    rst       = 1'b0;
    out_ready = 1'b1;

    // T1: full-scale exact product, three cycles after acceptance
    clear_vecs();
    push(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
    run_stream("t1", 1000, 0);

    // T2: mixed exact/approx vectors, all hand-derived
    clear_vecs();
    push(16'h0003, 16'h0003, 1'b1, 32'h0000_0007);
    push(16'h0003, 16'h0003, 1'b0, 32'h0000_0009);
    push(16'h00FF, 16'h0001, 1'b1, 32'h0000_00FF);
    push(16'h0100, 16'h0100, 1'b1, 32'h0001_0000);
    push(16'h1234, 16'h0010, 1'b0, 32'h0001_2340);
    push(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFD_F9FF);
    push(16'h0000, 16'hFFFF, 1'b0, 32'h0000_0000);
    push(16'h000F, 16'h000F, 1'b1, 32'h0000_007F);
    push(16'hFFFF, 16'h0001, 1'b0, 32'h0000_FFFF);
    push(16'h0011, 16'h0011, 1'b1, 32'h0000_0111);
    push(16'h00C0, 16'h0003, 1'b1, 32'h0000_01C0);
    push(16'h00C0, 16'h0003, 1'b0, 32'h0000_0240);
    run_stream("t2", 1000, 0);
    check("t2_cnt", approx_cnt, 7);

    // T4: back-to-back exact stream, out_ready low for 5 cycles at cycle 4
    clear_vecs();
    for (int i = 0; i < 12; i++)
      push(W'(i + 1), W'(i + 2), 1'b0, PW'((i + 1) * (i + 2)));
    run_stream("t4", 4, 5);
    check("t4_cnt", approx_cnt, 7);

    // T5: reset with transactions in flight
    in_valid  = 1'b1;
    in_a      = 16'h0003;
    in_b      = 16'h0003;
    in_approx = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t5_cnt_before", approx_cnt, 9);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_p", out_p, 0);
    check("t5_out_approx", out_approx, 0);
    check("t5_cnt", approx_cnt, 0);
    check("t5_in_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("t5_flushed", out_valid, 0);
    end

    // T6: counter saturation at 15; exact transactions leave it alone
    clear_vecs();
    for (int i = 0; i < 14; i++) push(W'(i << 8), 16'h0001, 1'b1, PW'(i << 8));
    run_stream("t6a", 1000, 0);
    check("t6_cnt14", approx_cnt, 14);
    clear_vecs();
    for (int i = 14; i < 20; i++) push(W'(i << 8), 16'h0001, 1'b1, PW'(i << 8));
    run_stream("t6b", 1000, 0);
    check("t6_cnt_sat", approx_cnt, 15);
    clear_vecs();
    for (int i = 0; i < 3; i++) push(W'(i + 5), 16'h0003, 1'b0, PW'((i + 5) * 3));
    run_stream("t6c", 1000, 0);
    check("t6_cnt_exact", approx_cnt, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
